// File: rtl/abro_input_cond.sv
`default_nettype none
// ============================================================================
//  Module   : abro_input_cond
//  Brief    : Input conditioning for the ABRO FSM. Each of two raw event
//             sources (A, B) is synchronised, debounced and turned into a
//             one-cycle rising-edge pulse gated by enable. Rejected
//             transitions (glitches) from both channels feed one saturating
//             counter.
//             STABLE_CNT legal range is 1..15 (4-bit stability counter).
//  Revision : 1.0 - initial release
// ============================================================================
module abro_input_cond #(
    parameter int STABLE_CNT = 4,
    parameter int GLITCH_W   = 8
) (
    input  logic                clk,
    input  logic                reset,      // asynchronous, active-low
    input  logic                a_raw,
    input  logic                b_raw,
    input  logic                enable,
    output logic                a_level,
    output logic                b_level,
    output logic                a_pulse,
    output logic                b_pulse,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    // Counter value at which a differing sample is accepted as the new level.
    localparam logic [3:0] C_LAST = 4'(STABLE_CNT - 1);

    // Channel index 0 is A, index 1 is B.
    logic [1:0]          raw;
    logic [1:0]          s1_q;
    logic [1:0]          s2_q;
    logic [3:0]          cnt_q [2];
    logic [3:0]          cnt_d [2];
    logic [1:0]          level_q;
    logic [1:0]          level_d;
    logic [1:0]          pulse_q;
    logic [1:0]          pulse_d;
    logic [1:0]          glitch_inc;
    logic [GLITCH_W:0]   glitch_sum;
    logic [GLITCH_W-1:0] glitch_cnt_q;
    logic [GLITCH_W-1:0] glitch_cnt_d;

    assign raw = {b_raw, a_raw};

    // Debounce rules per channel: agreement clears the counter (counting a
    // glitch if progress is thrown away), sustained disagreement is accepted
    // once the counter reaches C_LAST. The pulse is raised on the same edge
    // that the level becomes 1, so both show up in the same cycle.
    always_comb begin
        glitch_inc = 2'd0;
        for (int ch = 0; ch < 2; ch++) begin
            cnt_d[ch]   = cnt_q[ch];
            level_d[ch] = level_q[ch];
            pulse_d[ch] = 1'b0;
            if (s2_q[ch] == level_q[ch]) begin
                cnt_d[ch] = 4'd0;
                if (cnt_q[ch] != 4'd0) begin
                    glitch_inc = glitch_inc + 2'd1;
                end
            end else if (cnt_q[ch] == C_LAST) begin
                level_d[ch] = s2_q[ch];
                cnt_d[ch]   = 4'd0;
                pulse_d[ch] = s2_q[ch] & enable;
            end else begin
                cnt_d[ch] = cnt_q[ch] + 4'd1;
            end
        end
    end

    // Saturating glitch accumulator; the extra sum bit flags overflow so a
    // +2 step from all-ones minus one clamps rather than wraps.
    always_comb begin
        glitch_sum   = {1'b0, glitch_cnt_q} + (GLITCH_W + 1)'(glitch_inc);
        glitch_cnt_d = glitch_sum[GLITCH_W] ? '1 : glitch_sum[GLITCH_W-1:0];
    end

    // State registers: synchroniser, counters, levels, pulses, glitch count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q         <= 2'b00;
            s2_q         <= 2'b00;
            cnt_q[0]     <= 4'd0;
            cnt_q[1]     <= 4'd0;
            level_q      <= 2'b00;
            pulse_q      <= 2'b00;
            glitch_cnt_q <= '0;
        end else begin
            s1_q         <= raw;
            s2_q         <= s1_q;
            cnt_q[0]     <= cnt_d[0];
            cnt_q[1]     <= cnt_d[1];
            level_q      <= level_d;
            pulse_q      <= pulse_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign a_level    = level_q[0];
    assign b_level    = level_q[1];
    assign a_pulse    = pulse_q[0];
    assign b_pulse    = pulse_q[1];
    assign glitch_cnt = glitch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_abro_input_cond.sv
`default_nettype none
// ============================================================================
//  Module   : tb_abro_input_cond
//  Brief    : Self-checking bench for abro_input_cond. Three instances share
//             the stimulus: (STABLE_CNT=4,GLITCH_W=8), (4,2) and (1,8). A
//             behavioural model (sample delay line, disagreement streak,
//             unbounded glitch total clamped on compare) predicts every
//             output each cycle; directed checks pin the documented numbers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_abro_input_cond;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic enable = 1'b1;

    wire [2:0] al;
    wire [2:0] bl;
    wire [2:0] ap;
    wire [2:0] bp;
    wire [7:0] g0;
    wire [1:0] g1;
    wire [7:0] g2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    abro_input_cond #(.STABLE_CNT(4), .GLITCH_W(8)) u_dut (
        .clk(clk), .reset(reset), .a_raw(a_raw), .b_raw(b_raw), .enable(enable),
        .a_level(al[0]), .b_level(bl[0]), .a_pulse(ap[0]), .b_pulse(bp[0]),
        .glitch_cnt(g0)
    );

    abro_input_cond #(.STABLE_CNT(4), .GLITCH_W(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .a_raw(a_raw), .b_raw(b_raw), .enable(enable),
        .a_level(al[1]), .b_level(bl[1]), .a_pulse(ap[1]), .b_pulse(bp[1]),
        .glitch_cnt(g1)
    );

    abro_input_cond #(.STABLE_CNT(1), .GLITCH_W(8)) u_dut_s1 (
        .clk(clk), .reset(reset), .a_raw(a_raw), .b_raw(b_raw), .enable(enable),
        .a_level(al[2]), .b_level(bl[2]), .a_pulse(ap[2]), .b_pulse(bp[2]),
        .glitch_cnt(g2)
    );

    function automatic int sc(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic int gmax(input int i);
        return (i == 1) ? 3 : 255;
    endfunction

    // ---------------- reference model ----------------
    int m_s1  [3][2];
    int m_s2  [3][2];
    int m_lvl [3][2];
    int m_str [3][2];
    int m_pul [3][2];
    int m_gl  [3];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_gl[i] = 0;
                for (int c = 0; c < 2; c++) begin
                    m_s1[i][c] = 0; m_s2[i][c] = 0; m_lvl[i][c] = 0;
                    m_str[i][c] = 0; m_pul[i][c] = 0;
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                for (int c = 0; c < 2; c++) begin
                    m_pul[i][c] = 0;
                    if (m_s2[i][c] != m_lvl[i][c]) begin
                        m_str[i][c]++;
                        if (m_str[i][c] >= sc(i)) begin
                            m_lvl[i][c] = m_s2[i][c];
                            m_str[i][c] = 0;
                            if (m_lvl[i][c] == 1 && enable) m_pul[i][c] = 1;
                        end
                    end else begin
                        if (m_str[i][c] > 0) m_gl[i]++;
                        m_str[i][c] = 0;
                    end
                    m_s2[i][c] = m_s1[i][c];
                    m_s1[i][c] = (c == 0) ? int'(a_raw) : int'(b_raw);
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] gv;
        for (int i = 0; i < 3; i++) begin
            gv = (i == 0) ? 32'(g0) : (i == 1) ? 32'(g1) : 32'(g2);
            chk($sformatf("a_level[%0d]", i), 32'(al[i]), m_lvl[i][0]);
            chk($sformatf("b_level[%0d]", i), 32'(bl[i]), m_lvl[i][1]);
            chk($sformatf("a_pulse[%0d]", i), 32'(ap[i]), m_pul[i][0]);
            chk($sformatf("b_pulse[%0d]", i), 32'(bp[i]), m_pul[i][1]);
            chk($sformatf("glitch_cnt[%0d]", i), gv,
                (m_gl[i] > gmax(i)) ? gmax(i) : m_gl[i]);
        end
    endtask

    int edge_n, first_a0, first_a2, pa, pb, pab;

    task automatic mark();
        edge_n = 0; first_a0 = -1; first_a2 = -1; pa = 0; pb = 0; pab = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            edge_n++;
            check_all();
            if (ap[0]) pa++;
            if (bp[0]) pb++;
            if (ap[0] && bp[0]) pab++;
            if (al[0] && first_a0 < 0) first_a0 = edge_n;
            if (al[2] && first_a2 < 0) first_a2 = edge_n;
        end
    endtask

    task automatic glitch_shot(input logic ga, input logic gb);
        a_raw = ga; b_raw = gb;
        step(2);
        a_raw = 1'b0; b_raw = 1'b0;
        step(6);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1 check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        mark();
        // Reset: everything zero without any clock edge.
        #2 reset = 1'b0;
        #1 check_all();
        chk("reset_glitch", 32'(g0), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single A rise, held 20 cycles.
        mark();
        a_raw = 1'b1;
        step(20);
        chk("rise_latency", first_a0, 6);
        chk("rise_pulses", pa, 1);
        chk("rise_b_quiet", pb, 0);
        chk("s1_latency", first_a2, 3);
        chk("rise_glitch", 32'(g0), 0);
        a_raw = 1'b0;
        step(10);

        // Short A burst, then short B burst: both rejected as glitches.
        mark();
        a_raw = 1'b1;
        step(3);
        a_raw = 1'b0;
        step(8);
        chk("a_burst_glitch", 32'(g0), 1);
        chk("a_burst_pulse", pa, 0);
        b_raw = 1'b1;
        step(2);
        b_raw = 1'b0;
        step(8);
        chk("b_burst_glitch", 32'(g0), 2);
        chk("s1_no_glitch", 32'(g2), 0);

        // Simultaneous rise and fall.
        mark();
        a_raw = 1'b1; b_raw = 1'b1;
        step(10);
        chk("both_same_cycle", pab, 1);
        chk("both_a_once", pa, 1);
        chk("both_b_once", pb, 1);
        mark();
        a_raw = 1'b0; b_raw = 1'b0;
        step(10);
        chk("fall_no_pulse", pa + pb, 0);

        // Qualification while disabled is lost, not deferred.
        mark();
        enable = 1'b0;
        a_raw = 1'b1;
        step(10);
        chk("dis_level", 32'(al[0]), 1);
        enable = 1'b1;
        step(5);
        chk("dis_no_pulse", pa, 0);
        a_raw = 1'b0;
        step(10);
        a_raw = 1'b1;
        step(10);
        chk("reen_pulse", pa, 1);
        a_raw = 1'b0;
        step(10);

        // Reset mid-count, raw still high at release.
        mark();
        a_raw = 1'b1;
        step(4);
        pulse_reset();
        chk("mid_reset_level", 32'(al[0]), 0);
        mark();
        step(10);
        chk("post_reset_latency", first_a0, 6);
        chk("post_reset_pulse", pa, 1);
        chk("post_reset_glitch", 32'(g0), 0);
        a_raw = 1'b0;
        step(10);

        // Saturation on the 2-bit glitch counter.
        pulse_reset();
        glitch_shot(1'b1, 1'b0);
        chk("sat_step1", 32'(g1), 1);
        glitch_shot(1'b1, 1'b1);
        chk("sat_step2", 32'(g1), 3);
        glitch_shot(1'b1, 1'b0);
        chk("sat_step3", 32'(g1), 3);
        glitch_shot(1'b0, 1'b1);
        chk("sat_hold", 32'(g1), 3);
        chk("wide_count", 32'(g0), 5);

        // Randomised segments with occasional asynchronous resets.
        repeat (150) begin
            a_raw  = 1'($urandom_range(0, 1));
            b_raw  = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 3) != 0);
            step($urandom_range(1, 6));
            if ($urandom_range(0, 40) == 0) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/abro_input_cond.md
ABRO_INPUT_COND -- requirements
Module: abro_input_cond

Interface
- REQ-001: Parameter STABLE_CNT, default 4, consecutive sampled cycles a new input value must persist before it is accepted; legal range 1..15.
- REQ-002: Parameter GLITCH_W, default 8, width of the glitch counter.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset.
- REQ-005: a_raw  input  1  unsynchronised raw event source A.
- REQ-006: b_raw  input  1  unsynchronised raw event source B.
- REQ-007: enable  input  1  when high, pulse outputs may assert; when low, pulse outputs are suppressed.
- REQ-008: a_level  output  1  debounced level of A.
- REQ-009: b_level  output  1  debounced level of B.
- REQ-010: a_pulse  output  1  one-cycle pulse on debounced A rising edge; drives the ABRO FSM a input.
- REQ-011: b_pulse  output  1  one-cycle pulse on debounced B rising edge; drives the ABRO FSM b input.
- REQ-012: glitch_cnt  output  GLITCH_W  saturating count of rejected transitions, A and B combined.

Function
- REQ-013: Each channel SHALL pass its raw input through a two-flop synchroniser (s1 then s2); no logic SHALL sample s1 directly.
- REQ-014: Each channel SHALL hold a 4-bit stability counter and a debounced level register.
- REQ-015: Counter and level update rules, per rising edge:
  - s2 equals level: counter clears to 0.
  - s2 differs from level and counter < STABLE_CNT-1: counter increments.
  - s2 differs from level and counter == STABLE_CNT-1: level takes s2 and counter clears.
- REQ-016: Latency: a raw value stable from before edge 1 (the first edge at which s1 captures it) SHALL appear on *_level after edge STABLE_CNT+2. For the default STABLE_CNT=4, this is edge 6.
- REQ-017: Latency is identical for rising and falling transitions.
- REQ-018: *_pulse SHALL be registered and high for exactly one cycle, coincident with the first cycle the level reads 1 after a 0->1 level change, and only if enable was high at that edge.
- REQ-019: A 1->0 level change SHALL produce no pulse.
- REQ-020: A rising edge qualified while enable is low is lost; it SHALL NOT be deferred to a later cycle.
- REQ-021: A and B channels SHALL be fully independent.
- REQ-022: Simultaneous qualification of both channels SHALL assert a_pulse and b_pulse in the same cycle.
- REQ-023: Glitch detection: a glitch is any edge where the counter is non-zero and s2 equals level (counter clears without a level change). Each glitch SHALL increment glitch_cnt by 1.
- REQ-024: If A and B both glitch on the same edge, glitch_cnt SHALL increment by 2.
- REQ-025: glitch_cnt SHALL saturate at all-ones and never wrap; a +2 step from all-ones minus one SHALL land on all-ones.
- REQ-026: With STABLE_CNT=1, a level SHALL change after edge 3.
- REQ-027: With STABLE_CNT=1, a single differing s2 sample SHALL be accepted and no glitch SHALL be possible.

Reset
- REQ-028: While reset is low, all of the following SHALL be 0 immediately, independent of clk: s1, s2, counters, levels, pulses and glitch_cnt.
- REQ-029: A raw input that is already high at reset release SHALL be treated as a 0->1 transition and SHALL follow REQ-016 and REQ-018.
- REQ-030: Reset asserted mid-count SHALL discard partial progress with no pulse and no glitch increment.

Verification
- REQ-031: STABLE_CNT=4, enable=1; a_raw 0->1 held 20 cycles -> a_level=1 after edge 6; a_pulse high exactly one cycle; b outputs stay 0; glitch_cnt=0.
- REQ-032: a_raw high for 3 cycles then low -> a_level stays 0, no a_pulse, glitch_cnt=1. Then b_raw high for 2 cycles -> glitch_cnt=2.
- REQ-033: a_raw and b_raw rise on the same cycle -> a_pulse and b_pulse both high in the same single cycle. Then both fall -> levels return to 0 with no pulses.
- REQ-034: enable=0 during A qualification -> a_level=1 with no a_pulse. Then enable=1 with a_raw still high -> still no pulse. Then a_raw low, then high again -> one a_pulse.
- REQ-035: reset driven low for 1 cycle while the A counter=2 -> all outputs 0 at once. After release with a_raw still high -> a_pulse after edge 6.
- REQ-036: GLITCH_W=2; drive 5 glitches, including one simultaneous A+B glitch -> glitch_cnt steps 1, 3, 3 and holds at 3.
